// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, payload LSB first, optional parity, stop bit.
// Optional even-parity bit is built in when PISO_FRAME_TX_PARITY_EN is defined.
module piso_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] In_data,
    input  logic              In_valid,
    output logic              In_ready,
    output logic              Out,
    output logic              Busy,
    output logic              Frame_done
);

    // state  | meaning
    // IDLE   | line idle at 1, waiting for a payload
    // START  | driving the start bit (0)
    // DATA   | driving payload bits, LSB first
    // PARITY | driving even parity of the payload (parity build only)
    // STOP   | driving the stop bit (1); may accept the next payload
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef PISO_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              accept;
`ifdef PISO_FRAME_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign In_ready   = (state_q == IDLE) || (state_q == STOP);
    assign Busy       = (state_q != IDLE);
    assign Frame_done = (state_q == STOP);
    assign Out        = out_q;
    assign accept     = In_valid && In_ready;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b1;
`ifdef PISO_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
`ifdef PISO_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // out_d is the line level for the state being entered, so Out is a flop output.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
`ifdef PISO_FRAME_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d = START;
                    shift_d = In_data;
                    cnt_d   = '0;
                    out_d   = 1'b0;
`ifdef PISO_FRAME_TX_PARITY_EN
                    par_d   = ^In_data;
`endif
                end else begin
                    state_d = IDLE;
                    out_d   = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                out_d   = shift_q[0];
                shift_d = {1'b0, shift_q[DATA_W-1:1]};
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
`ifdef PISO_FRAME_TX_PARITY_EN
                    state_d = PARITY;
                    out_d   = par_q;
`else
                    state_d = STOP;
                    out_d   = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    out_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                end
            end
`ifdef PISO_FRAME_TX_PARITY_EN
            PARITY: begin
                state_d = STOP;
                out_d   = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/piso_frame_tx.md
PISO_FRAME_TX -- requirements
Module: piso_frame_tx

Interface
REQ-001 Parameter: DATA_W, 8, payload width in bits; legal range 2..16.
REQ-002 Port: Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: Rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: In_data  input  DATA_W  parallel payload; sampled only on an accepting edge.
REQ-005 Port: In_valid  input  1  producer offers In_data.
REQ-006 Port: In_ready  output  1  block can accept a payload this cycle.
REQ-007 Port: Out  output  1  registered serial line feeding the downstream serial-in shift chain; idle level 1.
REQ-008 Port: Busy  output  1  high while a frame is being driven on Out.
REQ-009 Port: Frame_done  output  1  high for exactly the cycle in which Out carries the stop bit.

Function
REQ-010 The block SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP, with all outputs registered or decoded from state only.
REQ-011 The block SHALL accept a payload on a rising edge where In_valid=1 and In_ready=1; In_ready SHALL be 1 in IDLE and STOP and 0 in all other states.
REQ-012 On accept, the block SHALL capture In_data into an internal DATA_W-bit shift register and enter START, so that Out=0 in the cycle after the accepting edge.
REQ-013 From START, the block SHALL enter DATA and drive the payload LSB first, one bit per cycle, for exactly DATA_W cycles, counted by a bit counter that wraps to 0 at DATA_W-1.
REQ-014 After the last data bit, the block SHALL enter PARITY when the parity feature is compiled in, otherwise STOP.
REQ-015 In STOP, the block SHALL drive Out=1 and assert Frame_done for one cycle.
REQ-016 From STOP, the block SHALL enter START if an accept occurs on that edge, giving back-to-back frames with no idle gap; otherwise it SHALL enter IDLE.
REQ-017 In IDLE, the block SHALL hold Out=1 and keep Busy=0; Busy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-018 While In_ready=0, the block SHALL ignore In_valid and In_data changes; a producer holding In_valid SHALL be accepted at the next STOP or IDLE edge.
REQ-019 Frame length SHALL be DATA_W+2 cycles without parity and DATA_W+3 with parity; accept-to-start latency SHALL be 1 cycle.

Reset
REQ-020 While Rst_n=0, the block SHALL force state=IDLE, Out=1, Busy=0, Frame_done=0, In_ready=1, bit counter=0 and shift register=0, and SHALL accept nothing.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately and asynchronously; the partial payload SHALL be discarded and not resent.
REQ-022 After Rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-023 Macro PISO_FRAME_TX_PARITY_EN: when defined, the block SHALL include the PARITY state and drive the even-parity bit (XOR of all payload bits) for one cycle between the last data bit and stop.
REQ-024 When PISO_FRAME_TX_PARITY_EN is undefined, the block SHALL contain no PARITY state or parity logic, and DATA SHALL go directly to STOP.

Verification
REQ-025 Parity on, accept 0xA5 -> Out over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1, with Frame_done high only on the 11th cycle.
REQ-026 Parity on, accept 0x07 -> parity cycle Out=1; parity off, accept 0x07 -> 10-cycle frame 0,1,1,1,0,0,0,0,0,1.
REQ-027 In_valid held high with 0x01 then 0xFF -> frame 2 start bit immediately follows frame 1 stop bit; Busy stays 1 throughout; Frame_done pulses every 11 cycles.
REQ-028 In_valid raised with 0x3C during DATA -> In_ready=0 and no capture until the STOP edge; the frame then carries 0x3C exactly once.
REQ-029 Rst_n pulled low during data bit 4 of 0xFF -> Out=1 and Busy=0 without waiting for a clock edge; after release Out stays 1 and no residual bits are emitted.
